// File: rtl/kyber_hpm_host_ctrl.sv
// Host sequencer for the single-PE Kyber polynomial multiplier.
// Define KYBER_HPM_HOST_CTRL_WATCHDOG_EN to enable the WAIT watchdog and err.
module kyber_hpm_host_ctrl #(
  parameter int PE_NUMBER = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic                    cmd_ab,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [12*PE_NUMBER-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [12*PE_NUMBER-1:0] m_data,
  output logic [7:0]              m_index,
  output logic                    load_a_f,
  output logic                    load_a_i,
  output logic                    load_b_f,
  output logic                    load_b_i,
  output logic                    read_a,
  output logic                    read_b,
  output logic                    start_ab,
  output logic                    start_fntt,
  output logic                    start_pwm2,
  output logic                    start_intt,
  output logic [12*PE_NUMBER-1:0] din,
  input  logic [12*PE_NUMBER-1:0] dout,
  input  logic                    done,
  output logic                    err
);
  localparam int W = 12 * PE_NUMBER;

  localparam logic [3:0] OP_LAF  = 4'd0;
  localparam logic [3:0] OP_LAI  = 4'd1;
  localparam logic [3:0] OP_LBF  = 4'd2;
  localparam logic [3:0] OP_LBI  = 4'd3;
  localparam logic [3:0] OP_FNTT = 4'd4;
  localparam logic [3:0] OP_PWM2 = 4'd5;
  localparam logic [3:0] OP_INTT = 4'd6;
  localparam logic [3:0] OP_RDA  = 4'd8;
  localparam logic [3:0] OP_RDB  = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_BURST, S_GAP, S_START,
    S_HOLD, S_WAIT, S_RDLAT, S_CAPT, S_DRAIN
  } state_t;

  state_t     r_state;
  state_t     w_nxt;
  logic [8:0] r_cnt;
  logic [8:0] w_cnt_nxt;
  logic [3:0] r_op;
  logic       r_ab;
  logic       w_acc;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [W-1:0] w_wdata;
  logic [7:0] w_raddr;
  logic [W-1:0] w_rdata;
  logic [7:0] w_bi;
  logic       w_is_i;
  logic       w_is_rd;
  logic       w_wd_hit;
  logic [W-1:0] r_buf [256];

  assign w_bi    = r_cnt[7:0] - 8'd1;
  assign w_is_i  = (r_op == OP_LAI) || (r_op == OP_LBI);
  assign w_is_rd = (r_op == OP_RDA) || (r_op == OP_RDB);
  assign w_rdata = r_buf[w_raddr];

  // Next-state, step counter and buffer port control
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_acc     = 1'b0;
    w_we      = 1'b0;
    w_waddr   = r_cnt[7:0];
    w_wdata   = s_data;
    w_raddr   = r_cnt[7:0];
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_acc     = 1'b1;
          w_cnt_nxt = 9'd0;
          case (cmd_op)
            OP_LAF, OP_LAI, OP_LBF, OP_LBI: w_nxt = S_FILL;
            OP_FNTT, OP_PWM2, OP_INTT:      w_nxt = S_START;
            OP_RDA, OP_RDB:                 w_nxt = S_START;
            default:                        w_nxt = S_IDLE;
          endcase
        end
      end
      S_FILL: begin
        if (s_valid) begin
          w_we = 1'b1;
          if (r_cnt == 9'd255) begin
            w_nxt     = S_BURST;
            w_cnt_nxt = 9'd0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      S_BURST: begin
        w_raddr = w_is_i ? {w_bi[7:2], w_bi[0], w_bi[1]} : w_bi;
        if (r_cnt == 9'd256) begin
          w_nxt     = S_GAP;
          w_cnt_nxt = 9'd0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      S_GAP, S_HOLD, S_RDLAT: begin
        if (r_cnt == 9'd1) begin
          w_cnt_nxt = 9'd0;
          case (r_state)
            S_GAP:   w_nxt = S_IDLE;
            S_HOLD:  w_nxt = S_WAIT;
            default: w_nxt = S_CAPT;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      S_START: begin
        w_cnt_nxt = 9'd0;
        w_nxt     = w_is_rd ? S_RDLAT : S_HOLD;
      end
      S_WAIT: begin
        if (done || w_wd_hit) w_nxt = S_IDLE;
      end
      S_CAPT: begin
        w_we    = 1'b1;
        w_waddr = {r_cnt[0], r_cnt[7:1]};
        w_wdata = dout;
        if (r_cnt == 9'd255) begin
          w_nxt     = S_DRAIN;
          w_cnt_nxt = 9'd0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      S_DRAIN: begin
        if (m_ready) begin
          if (r_cnt == 9'd255) begin
            w_nxt     = S_IDLE;
            w_cnt_nxt = 9'd0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      default: begin
        w_nxt     = S_IDLE;
        w_cnt_nxt = 9'd0;
      end
    endcase
  end

  // State, counter and latched command
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 9'd0;
      r_op    <= 4'd0;
      r_ab    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_acc) begin
        r_op <= cmd_op;
        r_ab <= cmd_ab;
      end
    end
  end

  // Coefficient buffer write port
  always_ff @(posedge clk) begin
    if (w_we && !reset) r_buf[w_waddr] <= w_wdata;
  end

`ifdef KYBER_HPM_HOST_CTRL_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WDW-1:0] r_wd;
  logic           r_err;

  assign w_wd_hit = (r_state == S_WAIT) && !done &&
                    (r_wd == WDW'(TIMEOUT_CYCLES - 1));
  assign err      = r_err;

  // WAIT cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd <= (r_state == S_WAIT && !done) ? r_wd + 1'b1 : '0;
      if (w_acc) r_err <= 1'b0;
      else if (w_wd_hit) r_err <= 1'b1;
    end
  end
`else
  assign w_wd_hit = 1'b0;
  assign err      = 1'b0;
`endif

  assign cmd_ready  = (r_state == S_IDLE);
  assign s_ready    = (r_state == S_FILL);
  assign m_valid    = (r_state == S_DRAIN);
  assign m_data     = m_valid ? w_rdata : '0;
  assign m_index    = m_valid ? r_cnt[7:0] : 8'd0;
  assign din        = (r_state == S_BURST && r_cnt != 9'd0) ? w_rdata : '0;
  assign load_a_f   = (r_state == S_BURST) && (r_cnt == 9'd0) && (r_op == OP_LAF);
  assign load_a_i   = (r_state == S_BURST) && (r_cnt == 9'd0) && (r_op == OP_LAI);
  assign load_b_f   = (r_state == S_BURST) && (r_cnt == 9'd0) && (r_op == OP_LBF);
  assign load_b_i   = (r_state == S_BURST) && (r_cnt == 9'd0) && (r_op == OP_LBI);
  assign read_a     = (r_state == S_START) && (r_op == OP_RDA);
  assign read_b     = (r_state == S_START) && (r_op == OP_RDB);
  assign start_fntt = (r_state == S_START) && (r_op == OP_FNTT);
  assign start_pwm2 = (r_state == S_START) && (r_op == OP_PWM2);
  assign start_intt = (r_state == S_START) && (r_op == OP_INTT);
  assign start_ab   = (start_fntt || start_pwm2 || start_intt) && r_ab;
endmodule
